// File: rtl/ram_arbiter_if.sv
// Request/response and RAM-port bundle between the fetch/LSU masters, the arbiter and the SDP RAM.
// The slave modport is the arbiter's view of it; the master modport is the core/RAM side.
interface ram_arbiter_if;
    logic        m0_req_i;
    logic [31:0] m0_addr_i;
    logic        m0_gnt_o;
    logic        m0_rvalid_o;
    logic [31:0] m0_rdata_o;
    logic        m0_err_o;

    logic        m1_req_i;
    logic        m1_we_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_wdata_i;
    logic        m1_gnt_o;
    logic        m1_rvalid_o;
    logic [31:0] m1_rdata_o;
    logic        m1_err_o;

    logic        ram_cs_o;
    logic        ram_re_o;
    logic [31:0] ram_raddr_o;
    logic        ram_we_o;
    logic [31:0] ram_waddr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;

    modport slave (
        input  m0_req_i, m0_addr_i,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        input  ram_rdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        output ram_cs_o, ram_re_o, ram_raddr_o, ram_we_o, ram_waddr_o, ram_wdata_o
    );

    modport master (
        output m0_req_i, m0_addr_i,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        output ram_rdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        input  ram_cs_o, ram_re_o, ram_raddr_o, ram_we_o, ram_waddr_o, ram_wdata_o
    );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one SDP RAM between instruction fetch (M0) and load/store (M1): read-port arbitration
// with M0 anti-starvation, write pass-through, region/alignment checks, 1-cycle responses.
module ram_arbiter #(
    parameter int unsigned IMEM_WORDS = 512,
    parameter int unsigned DMEM_WORDS = 512,
    parameter int unsigned MAX_WAIT   = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ram_arbiter_if.slave  bus,
    output logic [15:0]   err_cnt_o
);
    localparam logic [29:0] L_IMEM  = 30'(IMEM_WORDS);
    localparam logic [29:0] L_TOTAL = 30'(IMEM_WORDS + DMEM_WORDS);
    localparam logic [3:0]  L_MAX   = 4'(MAX_WAIT);

    logic [3:0]  r_starve;
    logic [15:0] r_err_cnt;
    logic        r_m0_pend_v, r_m0_pend_err;
    logic        r_m1_pend_v, r_m1_pend_err, r_m1_pend_wr;

    logic [29:0] w_m0_word, w_m1_word;
    logic        w_m0_fault, w_m1_fault;
    logic        w_conflict, w_m0_prio;
    logic        w_m0_gnt, w_m1_gnt;
    logic        w_m0_rd, w_m1_rd, w_m1_wr;
    logic        w_m0_flt_gnt, w_m1_flt_gnt;
    logic [16:0] w_err_sum;
    logic [15:0] w_err_cnt_d;
    logic [3:0]  w_starve_d;

    assign w_m0_word = bus.m0_addr_i[31:2];
    assign w_m1_word = bus.m1_addr_i[31:2];

    // Fetch is confined to the instruction region, which also bounds it below the total size.
    assign w_m0_fault = (|bus.m0_addr_i[1:0]) || (w_m0_word >= L_IMEM);
    assign w_m1_fault = (|bus.m1_addr_i[1:0]) || (w_m1_word >= L_TOTAL) ||
                        (bus.m1_we_i && (w_m1_word < L_IMEM));

    // Only a load competes with fetch for the read port; stores use the write port.
    assign w_conflict = bus.m0_req_i & bus.m1_req_i & ~bus.m1_we_i;
    assign w_m0_prio  = (r_starve == L_MAX);
    assign w_m0_gnt   = ~rst_i & bus.m0_req_i & (~w_conflict | w_m0_prio);
    assign w_m1_gnt   = ~rst_i & bus.m1_req_i & (~w_conflict | ~w_m0_prio);

    assign w_m0_rd      = w_m0_gnt & ~w_m0_fault;
    assign w_m1_rd      = w_m1_gnt & ~bus.m1_we_i & ~w_m1_fault;
    assign w_m1_wr      = w_m1_gnt & bus.m1_we_i & ~w_m1_fault;
    assign w_m0_flt_gnt = w_m0_gnt & w_m0_fault;
    assign w_m1_flt_gnt = w_m1_gnt & w_m1_fault;

    always_comb begin
        w_starve_d = r_starve;
        if (w_m0_gnt) begin
            w_starve_d = 4'd0;
        end else if (bus.m0_req_i && (r_starve != L_MAX)) begin
            w_starve_d = r_starve + 4'd1;
        end
    end

    assign w_err_sum   = {1'b0, r_err_cnt} + 17'(w_m0_flt_gnt) + 17'(w_m1_flt_gnt);
    assign w_err_cnt_d = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_starve      <= 4'd0;
            r_err_cnt     <= 16'd0;
            r_m0_pend_v   <= 1'b0;
            r_m0_pend_err <= 1'b0;
            r_m1_pend_v   <= 1'b0;
            r_m1_pend_err <= 1'b0;
            r_m1_pend_wr  <= 1'b0;
        end else begin
            r_starve      <= w_starve_d;
            r_err_cnt     <= w_err_cnt_d;
            r_m0_pend_v   <= w_m0_gnt;
            r_m0_pend_err <= w_m0_flt_gnt;
            r_m1_pend_v   <= w_m1_gnt;
            r_m1_pend_err <= w_m1_flt_gnt;
            r_m1_pend_wr  <= w_m1_gnt & bus.m1_we_i;
        end
    end

    assign bus.m0_gnt_o = w_m0_gnt;
    assign bus.m1_gnt_o = w_m1_gnt;

    // At most one of w_m0_rd / w_m1_rd can be set, so a simple priority mux suffices.
    assign bus.ram_re_o    = w_m0_rd | w_m1_rd;
    assign bus.ram_raddr_o = w_m0_rd ? bus.m0_addr_i : (w_m1_rd ? bus.m1_addr_i : 32'd0);
    assign bus.ram_we_o    = w_m1_wr;
    assign bus.ram_waddr_o = w_m1_wr ? bus.m1_addr_i : 32'd0;
    assign bus.ram_wdata_o = w_m1_wr ? bus.m1_wdata_i : 32'd0;
    assign bus.ram_cs_o    = bus.ram_re_o | bus.ram_we_o;

    // Responses are masked while in reset so a grant just before reset never surfaces.
    assign bus.m0_rvalid_o = ~rst_i & r_m0_pend_v;
    assign bus.m0_err_o    = ~rst_i & r_m0_pend_err;
    assign bus.m0_rdata_o  = (bus.m0_rvalid_o && !r_m0_pend_err) ? bus.ram_rdata_i : 32'd0;

    assign bus.m1_rvalid_o = ~rst_i & r_m1_pend_v;
    assign bus.m1_err_o    = ~rst_i & r_m1_pend_err;
    assign bus.m1_rdata_o  = (bus.m1_rvalid_o && !r_m1_pend_err && !r_m1_pend_wr) ?
                             bus.ram_rdata_i : 32'd0;

    assign err_cnt_o = rst_i ? 16'd0 : r_err_cnt;
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-read/single-write on-chip SDP RAM between an instruction-fetch master (M0) and a data load/store master (M1).
- Arbitrates the read port, passes writes through on the independent write port, and enforces region/alignment access rules.
- Returns responses with fixed 1-cycle latency.
- Sits between the core's fetch/LSU request ports and the RAM.

Parameters:
- IMEM_WORDS, 512, words in instruction region (word index 0..IMEM_WORDS-1)
- DMEM_WORDS, 512, words in data region (IMEM_WORDS..IMEM_WORDS+DMEM_WORDS-1)
- MAX_WAIT, 4, consecutive M0 losses before M0 gets priority (legal 1..15)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- m0_req_i  in  1  fetch request, held with address until granted
- m0_addr_i  in  32  fetch byte address
- m0_gnt_o  out  1  fetch accepted this cycle (combinational)
- m0_rvalid_o  out  1  fetch response valid
- m0_rdata_o  out  32  fetch data
- m0_err_o  out  1  fetch access fault, qualified by m0_rvalid_o
- m1_req_i  in  1  data request, held with its fields until granted
- m1_we_i  in  1  1=store, 0=load
- m1_addr_i  in  32  data byte address
- m1_wdata_i  in  32  store data
- m1_gnt_o  out  1  data accepted (combinational)
- m1_rvalid_o  out  1  data response valid (load data or store ack)
- m1_rdata_o  out  32  load data
- m1_err_o  out  1  data access fault, qualified by m1_rvalid_o
- ram_cs_o  out  1  ram_re_o | ram_we_o
- ram_re_o  out  1  read strobe
- ram_raddr_o  out  32  read byte address
- ram_we_o  out  1  write strobe
- ram_waddr_o  out  32  write byte address
- ram_wdata_o  out  32  write data
- ram_rdata_i  in  32  RAM read data, valid the cycle after a re strobe
- err_cnt_o  out  16  saturating count of faulted requests

Behaviour:
- Word index w = addr[31:2].
- Legality:
  - misaligned (addr[1:0] != 0) = fault
  - w >= IMEM_WORDS+DMEM_WORDS = fault
  - M0 with w >= IMEM_WORDS = fault (no fetch from data)
  - M1 store with w < IMEM_WORDS = fault (imem write-protected)
  - M1 loads from either region are legal
- Arbitration, evaluated combinationally each cycle:
  - M1 store never contends with M0; both may be granted in the same cycle.
  - Conflict = m0_req_i & m1_req_i & !m1_we_i.
  - On conflict, M1 wins unless starve_cnt == MAX_WAIT, in which case M0 wins.
  - Without conflict, every requester is granted.
  - Legality does not affect arbitration: a faulted request still takes its grant slot.
- starve_cnt (4-bit register):
  - increments when M0 requests and is not granted
  - clears on m0_gnt_o
  - holds otherwise
  - never exceeds MAX_WAIT
- RAM drive:
  - ram_re_o = legal granted read (M0 fetch or M1 load).
  - ram_raddr_o = granted reader's address; 0 when idle.
  - ram_we_o = legal granted M1 store, with ram_waddr_o/ram_wdata_o = M1 fields; 0 otherwise.
  - Faulted requests never assert any RAM strobe.
- Responses:
  - Registered per master: pend_v, pend_err, and (M1 only) pend_wr, set at grant.
  - mX_rvalid_o = pend_v exactly one cycle after grant. Grant in cycle N gives rvalid in N+1.
  - Back-to-back grants give rvalid every cycle.
  - rdata: ram_rdata_i when rvalid & !err & !store; else 0.
  - err_o = pend_err.
- err_cnt_o increments by 1 per faulted grant (2 if both masters fault in the same cycle) and saturates at 16'hFFFF.
- Reset:
  - All gnt, strobes, rvalid, err outputs are 0 during reset; starve_cnt = 0, err_cnt_o = 0, pending flags cleared.
  - A grant in the cycle before reset asserts produces no response.
  - The first grant is possible in the first cycle after rst_i deasserts.
- A request with no grant produces no response and no state change other than starve_cnt.

Test Plan:
- Reset, then M0 fetch addr 0x0000_0010 with imem[4]=0xDEAD_BEEF -> m0_gnt_o same cycle, ram_re_o=1 with raddr 0x10, next cycle m0_rvalid_o=1, m0_rdata_o=0xDEADBEEF, m0_err_o=0.
- M0 fetch 0x20 and M1 store 0x0000_0804 data 0x1234_5678 in the same cycle -> both granted, ram_re_o=1 and ram_we_o=1 together. Both rvalid next cycle; a subsequent M1 load of 0x804 returns 0x12345678.
- M0 and M1 loads requested continuously, MAX_WAIT=4 -> M1 granted cycles 0-3, M0 granted cycle 4, starve_cnt back to 0, M1 granted cycle 5. Pattern repeats; no cycle has two read grants.
- Faults: M1 store 0x0000_0100, M0 fetch 0x0000_0900, M1 load 0x0000_0802, M1 load 0x0000_1000 -> each granted, no RAM strobe, rvalid+err next cycle, rdata=0, err_cnt_o ends at 4.
- M0 granted at cycle N, rst_i asserted at N+1 -> m0_rvalid_o stays 0, err_cnt_o=0. Fetch at first post-reset cycle is granted and responds normally.
- err_cnt saturation: force 65,537 faulted requests -> err_cnt_o holds 16'hFFFF, no wrap.
